// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared Q8.8 constants, FSM states, error sign encoding and saturation helper
package cnn_pkg;

    localparam int FRAC_BITS = 8;
    localparam int ONE_VAL   = 1 << FRAC_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ERR    = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } fc_state_e;

    localparam logic signed [1:0] ERR_ZERO = 2'sb00;
    localparam logic signed [1:0] ERR_POS  = 2'sb01;
    localparam logic signed [1:0] ERR_NEG  = 2'sb11;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        logic signed [15:0] r;
        if (v > 17'sd32767) begin
            r = 16'sh7fff;
        end else if (v < -17'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_sat_update.sv
// rtl/fc_sat_update.sv - saturating w - err*delta for one weight or bias
module fc_sat_update
    import cnn_pkg::*;
(
    input  logic signed [15:0] w,
    input  logic signed [15:0] delta,
    input  logic signed [1:0]  err,
    output logic signed [15:0] w_new
);

    logic signed [16:0] w_ext;
    logic signed [16:0] d_ext;
    logic signed [16:0] sum;

    always_comb begin
        w_ext = {w[15], w};
        d_ext = {delta[15], delta};
        case (err)
            ERR_POS: sum = w_ext - d_ext;
            ERR_NEG: sum = w_ext + d_ext;
            default: sum = w_ext;
        endcase
        w_new = sat16(sum);
    end

endmodule

// File: rtl/fc_backward.sv
// rtl/fc_backward.sv - FC layer backward pass: L1 sign error, SGD weight/bias update, input gradient
module fc_backward
    import cnn_pkg::*;
#(
    parameter int IN_SIZE  = 120,
    parameter int OUT_SIZE = 10,
    parameter int LR_SHIFT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [15:0]  input_data   [IN_SIZE],
    input  logic signed [15:0]  weights      [IN_SIZE*OUT_SIZE],
    input  logic signed [15:0]  bias         [OUT_SIZE],
    input  logic signed [31:0]  predicted    [OUT_SIZE],
    input  logic [OUT_SIZE-1:0] ground_truth,
    output logic                busy,
    output logic                done,
    output logic signed [15:0]  weights_new  [IN_SIZE*OUT_SIZE],
    output logic signed [15:0]  bias_new     [OUT_SIZE],
    output logic signed [31:0]  grad_input   [IN_SIZE]
);

    localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int WW = (IN_SIZE*OUT_SIZE > 1) ? $clog2(IN_SIZE*OUT_SIZE) : 1;
    localparam logic signed [15:0] BIAS_DELTA = 16'(ONE_VAL >>> LR_SHIFT);

    fc_state_e          state_q, state_d;
    logic [OW-1:0]      o_q, o_d;
    logic [IW-1:0]      i_q, i_d;
    logic               done_q, done_d;
    logic signed [1:0]  err_q  [OUT_SIZE];
    logic signed [1:0]  err_d  [OUT_SIZE];
    logic signed [15:0] wn_q   [IN_SIZE*OUT_SIZE];
    logic signed [15:0] wn_d   [IN_SIZE*OUT_SIZE];
    logic signed [15:0] bn_q   [OUT_SIZE];
    logic signed [15:0] bn_d   [OUT_SIZE];
    logic signed [31:0] grad_q [IN_SIZE];
    logic signed [31:0] grad_d [IN_SIZE];

    logic [WW-1:0]      widx;
    logic signed [15:0] w_cur;
    logic signed [31:0] w_ext32;
    logic signed [15:0] delta;
    logic signed [1:0]  err_cur;
    logic signed [15:0] w_upd;
    logic signed [15:0] b_upd;
    logic signed [31:0] target;

    assign widx    = WW'(32'(o_q) * IN_SIZE + 32'(i_q));
    assign w_cur   = weights[widx];
    assign w_ext32 = {{16{w_cur[15]}}, w_cur};
    assign delta   = input_data[i_q] >>> LR_SHIFT;
    assign err_cur = err_q[o_q];

    fc_sat_update u_w_upd (
        .w     (w_cur),
        .delta (delta),
        .err   (err_cur),
        .w_new (w_upd)
    );

    fc_sat_update u_b_upd (
        .w     (bias[o_q]),
        .delta (BIAS_DELTA),
        .err   (err_cur),
        .w_new (b_upd)
    );

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        i_d     = i_q;
        done_d  = 1'b0;
        err_d   = err_q;
        wn_d    = wn_q;
        bn_d    = bn_q;
        grad_d  = grad_q;
        target  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ERR;
                    o_d     = '0;
                    i_d     = '0;
                    grad_d  = '{default: '0};
                end
            end
            ST_ERR: begin
                target = ground_truth[o_q] ? 32'(ONE_VAL) : '0;
                if (predicted[o_q] > target) begin
                    err_d[o_q] = ERR_POS;
                end else if (predicted[o_q] < target) begin
                    err_d[o_q] = ERR_NEG;
                end else begin
                    err_d[o_q] = ERR_ZERO;
                end
                if (o_q == OW'(OUT_SIZE-1)) begin
                    state_d = ST_UPDATE;
                    o_d     = '0;
                    i_d     = '0;
                end else begin
                    o_d = o_q + 1'b1;
                end
            end
            ST_UPDATE: begin
                // Gradient uses the original weight, so it reads weights[] rather than the update.
                wn_d[widx] = w_upd;
                case (err_cur)
                    ERR_POS: grad_d[i_q] = grad_q[i_q] + w_ext32;
                    ERR_NEG: grad_d[i_q] = grad_q[i_q] - w_ext32;
                    default: grad_d[i_q] = grad_q[i_q];
                endcase
                if (i_q == IW'(IN_SIZE-1)) begin
                    bn_d[o_q] = b_upd;
                    i_d       = '0;
                    if (o_q == OW'(OUT_SIZE-1)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        o_d = o_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            o_q     <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= '{default: '0};
            wn_q    <= '{default: '0};
            bn_q    <= '{default: '0};
            grad_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            i_q     <= i_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wn_q    <= wn_d;
            bn_q    <= bn_d;
            grad_q  <= grad_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign weights_new = wn_q;
    assign bias_new    = bn_q;
    assign grad_input  = grad_q;

endmodule

// File: tb/tb_fc_backward.sv
// tb/tb_fc_backward.sv - directed self-checking bench for fc_backward (small and default sizes)
module tb_fc_backward;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance: IN_SIZE=4, OUT_SIZE=2
    logic               rst_s, start_s, busy_s, done_s;
    logic signed [15:0] x_s  [4];
    logic signed [15:0] w_s  [8];
    logic signed [15:0] b_s  [2];
    logic signed [31:0] p_s  [2];
    logic [1:0]         gt_s;
    logic signed [15:0] wn_s [8];
    logic signed [15:0] bn_s [2];
    logic signed [31:0] g_s  [4];

    // Default instance: IN_SIZE=120, OUT_SIZE=10
    logic               rst_d, start_d, busy_d, done_d;
    logic signed [15:0] x_d  [120];
    logic signed [15:0] w_d  [1200];
    logic signed [15:0] b_d  [10];
    logic signed [31:0] p_d  [10];
    logic [9:0]         gt_d;
    logic signed [15:0] wn_d [1200];
    logic signed [15:0] bn_d [10];
    logic signed [31:0] g_d  [120];

    fc_backward #(.IN_SIZE(4), .OUT_SIZE(2), .LR_SHIFT(8)) u_small (
        .clk(clk), .rst(rst_s), .start(start_s),
        .input_data(x_s), .weights(w_s), .bias(b_s), .predicted(p_s), .ground_truth(gt_s),
        .busy(busy_s), .done(done_s),
        .weights_new(wn_s), .bias_new(bn_s), .grad_input(g_s)
    );

    fc_backward u_dflt (
        .clk(clk), .rst(rst_d), .start(start_d),
        .input_data(x_d), .weights(w_d), .bias(b_d), .predicted(p_d), .ground_truth(gt_d),
        .busy(busy_d), .done(done_d),
        .weights_new(wn_d), .bias_new(bn_d), .grad_input(g_d)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_pass(input int sel);
        if (sel == 0) start_s = 1'b1; else start_d = 1'b1;
        @(posedge clk); #1;
        if (sel == 0) start_s = 1'b0; else start_d = 1'b0;
    endtask

    // Edges counted from the sampling edge; -1 if done never rose within bound.
    task automatic wait_done(input int sel, input int bound, output int edges);
        edges = -1;
        for (int n = 1; n <= bound; n++) begin
            @(posedge clk); #1;
            if ((sel == 0) ? done_s : done_d) begin
                edges = n;
                break;
            end
        end
    endtask

    int e, first, busy_bad, done_cnt;
    int exp_w;

    initial begin
        rst_s = 1'b1; rst_d = 1'b1; start_s = 1'b0; start_d = 1'b0;
        gt_s = '0; gt_d = '0;
        for (int k = 0; k < 4; k++) x_s[k] = '0;
        for (int k = 0; k < 8; k++) w_s[k] = '0;
        for (int k = 0; k < 2; k++) begin b_s[k] = '0; p_s[k] = '0; end
        for (int k = 0; k < 120; k++) x_d[k] = '0;
        for (int k = 0; k < 1200; k++) w_d[k] = '0;
        for (int k = 0; k < 10; k++) begin b_d[k] = '0; p_d[k] = '0; end
        repeat (2) @(posedge clk);
        #1;

        check("rst_busy", busy_s, 0);
        check("rst_done", done_s, 0);
        for (int k = 0; k < 8; k++) check("rst_wn", wn_s[k], 0);
        for (int k = 0; k < 2; k++) check("rst_bn", bn_s[k], 0);
        for (int k = 0; k < 4; k++) check("rst_g", g_s[k], 0);
        rst_s = 1'b0; rst_d = 1'b0;
        @(posedge clk); #1;

        // Basic pass: err=[+1,0]
        x_s = '{16'sd256, -16'sd512, -16'sd1, 16'sd1024};
        w_s = '{16'sd100, 16'sd100, 16'sd100, 16'sd100, 16'sd50, 16'sd50, 16'sd50, 16'sd50};
        b_s = '{16'sd10, 16'sd20};
        p_s = '{32'sd300, 32'sd0};
        gt_s = 2'b01;
        start_pass(0);
        check("busy_after_start", busy_s, 1);
        wait_done(0, 50, e);
        check("small_latency", e, 10);
        check("small_busy_in_done", busy_s, 1);
        @(posedge clk); #1;
        check("small_done_single", done_s, 0);
        check("small_idle_busy", busy_s, 0);
        check("b_wn0", wn_s[0], 99);
        check("b_wn1", wn_s[1], 102);
        check("b_wn2", wn_s[2], 101);
        check("b_wn3", wn_s[3], 96);
        for (int k = 4; k < 8; k++) check("b_wn_row1", wn_s[k], 50);
        check("b_bn0", bn_s[0], 9);
        check("b_bn1", bn_s[1], 20);
        for (int k = 0; k < 4; k++) check("b_g", g_s[k], 100);

        // Reset while idle with nonzero outputs
        rst_s = 1'b1; #2;
        check("idle_rst_busy", busy_s, 0);
        check("idle_rst_done", done_s, 0);
        for (int k = 0; k < 8; k++) check("idle_rst_wn", wn_s[k], 0);
        for (int k = 0; k < 2; k++) check("idle_rst_bn", bn_s[k], 0);
        for (int k = 0; k < 4; k++) check("idle_rst_g", g_s[k], 0);
        @(posedge clk); #1;
        rst_s = 1'b0;
        @(posedge clk); #1;

        // Saturation: err=[+1,-1], delta=127
        for (int k = 0; k < 4; k++) x_s[k] = 16'sd32767;
        for (int k = 0; k < 4; k++) begin w_s[k] = -16'sd32768; w_s[4+k] = 16'sd32767; end
        b_s = '{-16'sd32768, 16'sd32767};
        p_s = '{32'sd300, 32'sd0};
        gt_s = 2'b10;
        start_pass(0);
        wait_done(0, 50, e);
        check("sat_latency", e, 10);
        for (int k = 0; k < 4; k++) check("sat_wn_lo", wn_s[k], -32768);
        for (int k = 4; k < 8; k++) check("sat_wn_hi", wn_s[k], 32767);
        check("sat_bn0", bn_s[0], -32768);
        check("sat_bn1", bn_s[1], 32767);
        for (int k = 0; k < 4; k++) check("sat_g", g_s[k], -65535);
        @(posedge clk); #1;

        // Second pass, err=-1 everywhere, all-zero ground truth
        x_s = '{16'sd512, -16'sd256, 16'sd0, 16'sd255};
        w_s = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd10, 16'sd20, 16'sd30, 16'sd40};
        b_s = '{16'sd0, 16'sd0};
        p_s = '{-32'sd5, -32'sd5};
        gt_s = 2'b00;
        start_pass(0);
        for (int k = 0; k < 4; k++) check("p2_g_cleared", g_s[k], 0);
        check("p2_wn_persist", wn_s[0], -32768);
        check("p2_bn_persist", bn_s[1], 32767);
        wait_done(0, 50, e);
        check("p2_latency", e, 10);
        check("p2_wn0", wn_s[0], 3);
        check("p2_wn1", wn_s[1], 1);
        check("p2_wn2", wn_s[2], 3);
        check("p2_wn3", wn_s[3], 4);
        check("p2_wn4", wn_s[4], 12);
        check("p2_wn5", wn_s[5], 19);
        check("p2_wn6", wn_s[6], 30);
        check("p2_wn7", wn_s[7], 40);
        check("p2_bn0", bn_s[0], 1);
        check("p2_bn1", bn_s[1], 1);
        check("p2_g0", g_s[0], -11);
        check("p2_g1", g_s[1], -22);
        check("p2_g2", g_s[2], -33);
        check("p2_g3", g_s[3], -44);
        @(posedge clk); #1;

        // start held high: the next pass is sampled two edges after done
        start_s = 1'b1;
        @(posedge clk); #1;
        wait_done(0, 50, e);
        check("held_first", e, 10);
        wait_done(0, 50, e);
        check("held_restart", e, 12);
        start_s = 1'b0;
        for (int k = 0; k < 4; k++) check("held_g", g_s[k], -11 * (k + 1));
        repeat (2) @(posedge clk);
        #1;
        check("held_stop_busy", busy_s, 0);

        // Default sizes: latency, ignored start, busy coverage
        for (int k = 0; k < 120; k++) x_d[k] = 16'sd256;
        for (int k = 0; k < 1200; k++) w_d[k] = 16'sd1000;
        for (int k = 0; k < 10; k++) begin b_d[k] = '0; p_d[k] = '0; end
        gt_d = 10'b0000001000;
        start_pass(1);
        first = -1; busy_bad = 0; done_cnt = 0;
        for (int n = 1; n <= 1211; n++) begin
            @(posedge clk); #1;
            if (n == 499) start_d = 1'b1;
            if (n == 500) start_d = 1'b0;
            if (done_d) begin
                done_cnt++;
                if (first < 0) first = n;
            end
            if (n <= 1210 && !busy_d) busy_bad++;
        end
        check("dflt_latency", first, 1210);
        check("dflt_done_count", done_cnt, 1);
        check("dflt_busy_gaps", busy_bad, 0);
        check("dflt_idle_busy", busy_d, 0);
        for (int o = 0; o < 10; o++) begin
            for (int i = 0; i < 120; i++) check("dflt_wn", wn_d[o*120+i], (o == 3) ? 1001 : 1000);
            check("dflt_bn", bn_d[o], (o == 3) ? 1 : 0);
        end
        for (int i = 0; i < 120; i++) check("dflt_g", g_d[i], -1000);

        // Reset mid-pass, then a clean pass with new inputs
        start_pass(1);
        done_cnt = 0;
        for (int n = 1; n < 600; n++) begin
            @(posedge clk); #1;
            if (done_d) done_cnt++;
        end
        @(posedge clk); #1;
        rst_d = 1'b1; #1;
        check("mid_rst_pre_done", done_cnt, 0);
        check("mid_rst_busy", busy_d, 0);
        check("mid_rst_done", done_d, 0);
        for (int k = 0; k < 1200; k++) check("mid_rst_wn", wn_d[k], 0);
        for (int k = 0; k < 10; k++) check("mid_rst_bn", bn_d[k], 0);
        for (int k = 0; k < 120; k++) check("mid_rst_g", g_d[k], 0);
        @(posedge clk); #1;
        rst_d = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (done_d || busy_d) done_cnt++;
        end
        check("post_rst_quiet", done_cnt, 0);

        for (int k = 0; k < 120; k++) x_d[k] = (k % 2 == 0) ? 16'sd512 : -16'sd512;
        for (int k = 0; k < 1200; k++) w_d[k] = 16'(k);
        p_d[0] = 32'sd1000;
        p_d[9] = -32'sd7;
        gt_d = 10'b0000000001;
        start_pass(1);
        wait_done(1, 1300, e);
        check("rerun_latency", e, 1210);
        for (int o = 0; o < 10; o++) begin
            for (int i = 0; i < 120; i++) begin
                exp_w = o * 120 + i;
                if (o == 0) exp_w = exp_w + ((i % 2 == 0) ? -2 : 2);
                if (o == 9) exp_w = exp_w + ((i % 2 == 0) ? 2 : -2);
                check("rerun_wn", wn_d[o*120+i], exp_w);
            end
            check("rerun_bn", bn_d[o], (o == 0) ? -1 : ((o == 9) ? 1 : 0));
        end
        for (int i = 0; i < 120; i++) check("rerun_g", g_d[i], -1080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_backward.md
Name: fc_backward

Overview:
- Backward pass of the fully connected layer. Runs after L1 loss calculation (FC_B state of the training FSM).
- Consumes FC inputs, current weights/bias, predicted outputs and the one-hot ground truth.
- Produces SGD-updated weights/bias and the input gradient that feeds max-pool backward.
- Because L1 loss is used, the per-output error is a sign (-1/0/+1). The datapath therefore needs only add/sub/shift, no multiplier.

Parameters:
- IN_SIZE, 120, FC input vector length.
- OUT_SIZE, 10, FC output vector length (classes).
- LR_SHIFT, 8, learning rate = 2^-LR_SHIFT, applied as an arithmetic right shift.
- ONE_VAL, 256, Q8.8 encoding of 1.0; used as the target value for the hot class and as the bias input.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one backward pass; sampled only in IDLE.
- input_data  in  [15:0] x IN_SIZE (unpacked)  FC input activations, signed Q8.8.
- weights  in  [15:0] x IN_SIZE*OUT_SIZE  signed Q8.8; index o*IN_SIZE+i.
- bias  in  [15:0] x OUT_SIZE  signed Q8.8.
- predicted  in  [31:0] x OUT_SIZE  signed FC forward outputs.
- ground_truth  in  OUT_SIZE  one-hot target.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle completion pulse.
- weights_new  out  [15:0] x IN_SIZE*OUT_SIZE  updated weights.
- bias_new  out  [15:0] x OUT_SIZE  updated bias.
- grad_input  out  [31:0] x IN_SIZE  dL/dx, signed.

Behaviour:
- Reset (async): state=IDLE. busy, done, o/i counters, err[] = 0. All weights_new, bias_new, grad_input = 0.
- Inputs are read live, not latched. They must stay stable from the start-sampling edge until done.
- States: IDLE -> ERR -> UPDATE -> DONE -> IDLE.
- IDLE: if start, go to ERR. Clear o=0 and all grad_input=0. Otherwise hold outputs.
- ERR: one output per edge, o=0..OUT_SIZE-1.
  - target_o = ground_truth[o] ? ONE_VAL : 0, compared as a signed 32-bit value.
  - err[o] = +1 if predicted[o] > target_o, -1 if less, 0 if equal. Stored as a 2-bit signed value.
  - After o=OUT_SIZE-1, go to UPDATE with o=0, i=0.
- UPDATE: one (o,i) pair per edge; i is the inner loop, o the outer.
  - delta = input_data[i] >>> LR_SHIFT (arithmetic, floor).
  - weights_new[o*IN_SIZE+i] = sat16(weights[...] - err[o]*delta).
  - grad_input[i] += err[o]*weights[o*IN_SIZE+i], using the original weight, not the updated one.
  - When i=IN_SIZE-1: bias_new[o] = sat16(bias[o] - err[o]*(ONE_VAL >>> LR_SHIFT)).
  - After (OUT_SIZE-1, IN_SIZE-1): done<=1, go to DONE.
- DONE: done<=0, go to IDLE.
- Latency: the sampling edge is E0. done rises on edge E0+OUT_SIZE+OUT_SIZE*IN_SIZE (1210 with defaults) and is high for exactly one cycle. Back-to-back passes need 2 more edges (DONE->IDLE, then start sampled).
- Arithmetic widths:
  - sat16 computes in 17 bits and clamps to [-32768, 32767].
  - grad_input is a 32-bit signed accumulator; its magnitude is at most OUT_SIZE*32768, so it never overflows. No saturation is applied.
- Boundary cases:
  - start while busy: ignored.
  - start held high: a new pass begins each time the FSM returns to IDLE.
  - err=0 for an output: its weights and bias pass through unchanged but are still written.
  - all-zero ground_truth: legal; every target is 0.
  - rst mid-pass: immediate return to reset values, no done pulse.
  - Outputs persist after done until the next start, which clears grad_input only.

Decomposition:
- Shared package cnn_pkg:
  - Q8.8 constants (FRAC_BITS=8, ONE_VAL).
  - state encoding localparams.
  - err sign encoding.
  - sat16 function.
- One sub-module, fc_sat_update: combinational w - err*delta with 17-bit saturation. It is reused for both the weight and bias paths.

Test Plan:
1. Reset: assert rst mid-idle -> busy=0, done=0, all weights_new, bias_new, grad_input = 0.
2. IN_SIZE=4, OUT_SIZE=2. x=[256,-512,-1,1024], w row0=[100,100,100,100], row1=[50,50,50,50], bias=[10,20], predicted=[300,0], gt=2'b01.
   - Expected err=[+1,0].
   - weights_new row0=[99,102,101,96]; row1 unchanged.
   - bias_new=[9,20].
   - grad_input=[100,100,100,100].
   - done on edge 2+8=10 after E0.
3. Saturation:
   - w=-32768, x=32767, err=+1 -> -32768.
   - w=32767, x=32767, err=-1 (predicted=0 < target 256) -> 32767.
4. Defaults: done exactly 1210 edges after E0, single cycle. A start pulse at edge E0+500 is ignored; busy is high from E0+1 through the DONE cycle.
5. rst asserted at edge E0+600 -> immediate IDLE, all outputs 0, no done. A later start then completes normally with correct values.
6. Second pass with err=-1 on all outputs -> grad_input is cleared at start and equals the negated column sums of the new inputs, with no carry-over from the previous pass.
